// File: rtl/ram_line_reverser_pkg.sv
// Shared definitions for the scanline reverser: read-FSM states and default geometry.
package sgm_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_LINE_LENGTH = 640;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Line address width; a line always holds at least two words.
  function automatic int unsigned addr_width(input int unsigned line_length);
    return (line_length > 2) ? $clog2(line_length) : 1;
  endfunction

endpackage

// File: rtl/ram_line_reverser_if.sv
// Stream bus for the line reverser: input word stream in, reversed stream out.
interface ram_line_reverser_if
  import sgm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_last;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );

endinterface

// File: rtl/ram_line_reverser_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/ram_line_reverser.sv
// Ping-pong scanline reverser: lines are written left-to-right and read back right-to-left.
// Optional feature: define RAM_LINE_REVERSER_FLUSH_EN to add the flush input.
module ram_line_reverser
  import sgm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned LINE_LENGTH = DEF_LINE_LENGTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
`ifdef RAM_LINE_REVERSER_FLUSH_EN
  input  logic flush,
`endif
  ram_line_reverser_if.slave bus
);

  localparam int unsigned   AW        = addr_width(LINE_LENGTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_LENGTH - 1);

  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            full_q, full_d, full_set, full_clr;
  logic                  wr_en;
  logic [AW-1:0]         rd_addr_q;
  logic                  rd_bank_q;
  rd_state_e             state_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  in_ready;
  logic                  accept;
  logic                  issue;
  logic                  rd_last;
  logic [DATA_WIDTH-1:0] rd_data;

  assign in_ready = ~full_q[wr_bank_q];
  assign accept   = bus.in_valid & in_ready & ce;
  assign issue    = (state_q == READ) & (~out_valid_q | bus.out_ready) & ce;
  assign rd_last  = (rd_addr_q == '0);

  // Write side: fill the current bank, then hand it to the reader and swap banks.
  always_comb begin
    wr_en     = accept;
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    full_set  = '0;
    if (accept) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d           = '0;
        wr_bank_d           = ~wr_bank_q;
        full_set[wr_bank_q] = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
`ifdef RAM_LINE_REVERSER_FLUSH_EN
    if (flush && ce) begin
      wr_en     = 1'b0;
      wr_addr_d = '0;
      wr_bank_d = wr_bank_q;
      full_set  = '0;
    end
`endif
  end

  always_comb begin
    full_clr = '0;
    if (issue && rd_last) begin
      full_clr[rd_bank_q] = 1'b1;
    end
  end

  // Set and clear only ever target different banks, so both apply in one cycle.
  assign full_d = (full_q | full_set) & ~full_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
    end else if (ce) begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q   <= READ;
            rd_addr_q <= LAST_ADDR;
          end
        end
        READ: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q - 1'b1;
            if (rd_last) begin
              state_q   <= IDLE;
              rd_bank_q <= ~rd_bank_q;
            end
          end
        end
      endcase
      if (issue) begin
        out_valid_q <= 1'b1;
        out_last_q  <= rd_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Bank select is the address MSB, so each bank spans a power-of-two window.
  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW + 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_addr_q}),
    .wdata_i (bus.data_in),
    .re_i    (issue),
    .raddr_i ({rd_bank_q, rd_addr_q}),
    .rdata_o (rd_data)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = rd_data;
  assign bus.out_last  = out_last_q;

`ifndef SYNTHESIS
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> !full_q[wr_bank_q]);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !(bus.out_ready && ce)) |=>
      (out_valid_q && $stable(rd_data) && $stable(out_last_q)));
`endif

endmodule

// File: doc/ram_line_reverser.md
RAM_LINE_REVERSER -- requirements
Module: ram_line_reverser

Interface
REQ-001 DATA_WIDTH SHALL be a parameter, default 8: pixel/cost word width.
REQ-002 LINE_LENGTH SHALL be a parameter, default 640: words per scanline, minimum 2.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 ce  input  1  SHALL be the clock enable; ce=0 freezes all state and outputs.
REQ-006 in_valid  input  1  SHALL qualify data_in.
REQ-007 in_ready  output  1  SHALL indicate a word is accepted when in_valid=1, in_ready=1 and ce=1.
REQ-008 data_in  input  DATA_WIDTH  SHALL be the input word, in left-to-right scan order.
REQ-009 out_valid  output  1  SHALL qualify data_out.
REQ-010 out_ready  input  1  SHALL be the downstream ready; a transfer occurs when out_valid=1, out_ready=1 and ce=1.
REQ-011 data_out  output  DATA_WIDTH  SHALL be the output word, in right-to-left order within each line.
REQ-012 out_last  output  1  SHALL mark the final word of each reversed line, which is input word 0.

Function
REQ-013 Storage SHALL be two banks of LINE_LENGTH words (ping-pong), addressed {bank, addr}, with addr width $clog2(LINE_LENGTH).
REQ-014 Write side: accepted words SHALL be stored at wr_addr 0,1,...,LINE_LENGTH-1 of bank wr_bank; after addr LINE_LENGTH-1, full[wr_bank] SHALL set, wr_addr SHALL wrap to 0, and wr_bank SHALL toggle.
REQ-015 in_ready SHALL equal !full[wr_bank] (registered state only; no combinational path from out_ready).
REQ-016 Read FSM SHALL have two states: IDLE and READ.
REQ-017 IDLE -> READ SHALL occur when full[rd_bank]=1; rd_addr SHALL load LINE_LENGTH-1.
REQ-018 In READ, a RAM read SHALL be issued when (!out_valid || out_ready) && ce, and rd_addr SHALL decrement after each issue.
REQ-019 On issue at rd_addr 0: full[rd_bank] SHALL clear, rd_bank SHALL toggle, and the FSM SHALL go to IDLE. If the other bank is already full, the next cycle SHALL enter READ again, giving at most one bubble per line.
REQ-020 RAM read latency SHALL be 1 cycle, and data_out SHALL be driven directly from the RAM output register, enabled only on issue.
REQ-021 out_valid SHALL set on issue, hold while out_ready=0, and clear on a transfer with no new issue.
REQ-022 out_last SHALL be registered alongside data_out: 1 for the word read from addr 0.
REQ-023 Latency: the first reversed word SHALL be valid 2 cycles after the last word of its line is accepted, assuming out_ready=1.
REQ-024 When both banks are full, in_ready SHALL be 0 and input SHALL stall; no word SHALL be overwritten or dropped.
REQ-025 A set of full[a] and a clear of full[b] in the same cycle (a != b) SHALL both take effect.
REQ-026 data_out and out_last SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst_n=0 SHALL immediately force wr_addr=0, wr_bank=0, rd_bank=0, rd_addr=0, full=2'b00, FSM=IDLE, out_valid=0, out_last=0, data_out=0, in_ready=1 after release.
REQ-028 Reset mid-line SHALL discard all buffered data; RAM contents need not be cleared.

Configuration
REQ-029 With RAM_LINE_REVERSER_FLUSH_EN defined, an input port flush (1 bit) SHALL exist. flush=1 with ce=1 SHALL reset wr_addr to 0 and discard the partially written line. Read side and full banks SHALL be unaffected. flush SHALL take priority over a simultaneous write.
REQ-030 Without RAM_LINE_REVERSER_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
REQ-031 Shared package sgm_pkg SHALL hold the read-FSM state typedef (IDLE, READ) and the default DATA_WIDTH/LINE_LENGTH constants.
REQ-032 The RAM SHALL be a sub-module sdp_ram: simple dual-port, depth 2*LINE_LENGTH, registered read with read enable, and async-reset output register.

Verification (LINE_LENGTH=4, DATA_WIDTH=8)
REQ-033 Stream 1,2,3,4 with out_ready=1 -> out 4,3,2,1, with out_last on 1; first out_valid 2 cycles after 4 is accepted.
REQ-034 Continuous input 0..15, out_ready=1 -> out 3,2,1,0,7,6,5,4,11,10,9,8,15,14,13,12, with in_ready never 0.
REQ-035 Input 0..11, out_ready=0 -> in_ready falls after word 7; words 8..11 stall; out_valid holds 3. Then raise out_ready -> 3..0,7..4,11..8, with nothing lost.
REQ-036 Random out_ready toggling over 20 lines -> output equals the per-line reversal of the input, with data_out stable while stalled.
REQ-037 Assert rst_n=0 after writing 1,2 -> out_valid=0 and in_ready=1 immediately; then 5,6,7,8 -> out 8,7,6,5.
REQ-038 (FLUSH_EN) Write 1,2, flush, then 5,6,7,8 -> out 8,7,6,5; ce=0 for 3 cycles mid-line -> no state change.
